// File: rtl/baseline_validate.sv
// rtl/baseline_validate.sv - in-order prediction validation queue between value predictor and its feedback port
//
// Holds predictions (pc, result, confidence) in program order until commit, then
// compares the stored result against the architectural value and reports it back.
//
// Ports:
//   clk_i, rst_i         clock (rising edge), asynchronous active-high reset
//   pred_*_i             per-lane prediction enqueue (lane 0 oldest), qualified by pred_valid_i
//   cm_actual_i          per-lane architectural result, qualified by cm_valid_i
//   flush_i              synchronous flush: empties the queue, drops this cycle's traffic
//   fb_*_o               registered per-lane feedback (one cycle after commit)
//   count_o              occupied entries; empty_o / full_o derived from it
//   overflow_o           sticky: an enqueue batch was dropped for lack of space
//   underflow_o          sticky: a commit batch asked for more entries than were held
module baseline_validate #(
    parameter int P_NUM_PRED    = 2,
    parameter int P_QUEUE_DEPTH = 16,
    localparam int P_PTR_WIDTH  = $clog2(P_QUEUE_DEPTH)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [P_NUM_PRED*32-1:0]   pred_pc_i,
    input  logic [P_NUM_PRED*32-1:0]   pred_result_i,
    input  logic [P_NUM_PRED-1:0]      pred_conf_i,
    input  logic [P_NUM_PRED-1:0]      pred_valid_i,
    input  logic [P_NUM_PRED*32-1:0]   cm_actual_i,
    input  logic [P_NUM_PRED-1:0]      cm_valid_i,
    input  logic                       flush_i,
    output logic [P_NUM_PRED*32-1:0]   fb_pc_o,
    output logic [P_NUM_PRED*32-1:0]   fb_actual_o,
    output logic [P_NUM_PRED-1:0]      fb_mispredict_o,
    output logic [P_NUM_PRED-1:0]      fb_conf_o,
    output logic [P_NUM_PRED-1:0]      fb_valid_o,
    output logic [P_PTR_WIDTH:0]       count_o,
    output logic                       empty_o,
    output logic                       full_o,
    output logic                       overflow_o,
    output logic                       underflow_o
);

    // Two spare bits so count - n_deq + n_enq can exceed the depth without wrapping.
    localparam int CW = P_PTR_WIDTH + 2;
    localparam logic [CW-1:0]          DEPTH_C = CW'(P_QUEUE_DEPTH);
    localparam logic [CW-1:0]          ONE_C   = CW'(1);
    localparam logic [P_PTR_WIDTH-1:0] PONE_C  = P_PTR_WIDTH'(1);
    localparam logic [P_PTR_WIDTH:0]   FULL_C  = (P_PTR_WIDTH+1)'(P_QUEUE_DEPTH);

    logic [31:0] mem_pc_q  [P_QUEUE_DEPTH];
    logic [31:0] mem_res_q [P_QUEUE_DEPTH];
    logic        mem_conf_q[P_QUEUE_DEPTH];

    logic [P_PTR_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [P_PTR_WIDTH:0]   count_q, count_d;
    logic                   empty_q, full_q, ovf_q, ovf_d, udf_q, udf_d;

    logic [P_NUM_PRED*32-1:0] fb_pc_q, fb_pc_d, fb_actual_q, fb_actual_d;
    logic [P_NUM_PRED-1:0]    fb_mis_q, fb_mis_d, fb_conf_q, fb_conf_d, fb_valid_q, fb_valid_d;

    logic [CW-1:0]          n_enq, n_deq, n_deq_acc, after_deq, sum_w;
    logic [P_PTR_WIDTH-1:0] enq_run, deq_run;
    logic [P_PTR_WIDTH-1:0] wr_idx[P_NUM_PRED];
    logic [P_PTR_WIDTH-1:0] rd_idx[P_NUM_PRED];
    logic [P_NUM_PRED-1:0]  wr_en;
    logic                   underflow_det, overflow_det;

    always_comb begin
        n_enq   = '0;
        n_deq   = '0;
        enq_run = '0;
        deq_run = '0;
        // Compaction: each valid lane takes the next slot after the valid lanes below it.
        for (int j = 0; j < P_NUM_PRED; j++) begin
            wr_idx[j] = tail_q + enq_run;
            rd_idx[j] = head_q + deq_run;
            if (pred_valid_i[j]) begin
                n_enq   = n_enq + ONE_C;
                enq_run = enq_run + PONE_C;
            end
            if (cm_valid_i[j]) begin
                n_deq   = n_deq + ONE_C;
                deq_run = deq_run + PONE_C;
            end
        end

        underflow_det = n_deq > {1'b0, count_q};
        n_deq_acc     = underflow_det ? '0 : n_deq;
        after_deq     = {1'b0, count_q} - n_deq_acc;
        // Space freed by this cycle's accepted commits is usable by this cycle's enqueues.
        sum_w         = after_deq + n_enq;
        overflow_det  = sum_w > DEPTH_C;

        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        udf_d       = udf_q;
        wr_en       = '0;
        fb_pc_d     = '0;
        fb_actual_d = '0;
        fb_mis_d    = '0;
        fb_conf_d   = '0;
        fb_valid_d  = '0;

        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            udf_d  = udf_q | underflow_det;
            ovf_d  = ovf_q | overflow_det;
            head_d = head_q + n_deq_acc[P_PTR_WIDTH-1:0];
            if (overflow_det) begin
                count_d = after_deq[P_PTR_WIDTH:0];
            end else begin
                tail_d  = tail_q + n_enq[P_PTR_WIDTH-1:0];
                count_d = sum_w[P_PTR_WIDTH:0];
                wr_en   = pred_valid_i;
            end
            for (int j = 0; j < P_NUM_PRED; j++) begin
                if (cm_valid_i[j] && !underflow_det) begin
                    fb_valid_d[j]          = 1'b1;
                    fb_pc_d[j*32 +: 32]    = mem_pc_q[rd_idx[j]];
                    fb_actual_d[j*32 +: 32] = cm_actual_i[j*32 +: 32];
                    fb_mis_d[j]            = mem_res_q[rd_idx[j]] != cm_actual_i[j*32 +: 32];
                    fb_conf_d[j]           = mem_conf_q[rd_idx[j]];
                end
            end
        end
    end

    // Entry storage carries no reset; occupancy alone decides what is live.
    always_ff @(posedge clk_i) begin
        for (int j = 0; j < P_NUM_PRED; j++) begin
            if (wr_en[j]) begin
                mem_pc_q[wr_idx[j]]   <= pred_pc_i[j*32 +: 32];
                mem_res_q[wr_idx[j]]  <= pred_result_i[j*32 +: 32];
                mem_conf_q[wr_idx[j]] <= pred_conf_i[j];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            fb_pc_q     <= '0;
            fb_actual_q <= '0;
            fb_mis_q    <= '0;
            fb_conf_q   <= '0;
            fb_valid_q  <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            empty_q     <= count_d == '0;
            full_q      <= count_d == FULL_C;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
            fb_pc_q     <= fb_pc_d;
            fb_actual_q <= fb_actual_d;
            fb_mis_q    <= fb_mis_d;
            fb_conf_q   <= fb_conf_d;
            fb_valid_q  <= fb_valid_d;
        end
    end

    assign fb_pc_o         = fb_pc_q;
    assign fb_actual_o     = fb_actual_q;
    assign fb_mispredict_o = fb_mis_q;
    assign fb_conf_o       = fb_conf_q;
    assign fb_valid_o      = fb_valid_q;
    assign count_o         = count_q;
    assign empty_o         = empty_q;
    assign full_o          = full_q;
    assign overflow_o      = ovf_q;
    assign underflow_o     = udf_q;

endmodule

// File: tb/tb_baseline_validate.sv
// tb/tb_baseline_validate.sv - self-checking bench for baseline_validate
module tb_baseline_validate;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [63:0] pred_pc_i, pred_result_i, cm_actual_i;
    logic [1:0]  pred_conf_i, pred_valid_i, cm_valid_i;
    logic        flush_i;
    logic [63:0] fb_pc_o, fb_actual_o;
    logic [1:0]  fb_mispredict_o, fb_conf_o, fb_valid_o;
    logic [4:0]  count_o;
    logic        empty_o, full_o, overflow_o, underflow_o;

    baseline_validate #(.P_NUM_PRED(2), .P_QUEUE_DEPTH(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .pred_pc_i(pred_pc_i), .pred_result_i(pred_result_i),
        .pred_conf_i(pred_conf_i), .pred_valid_i(pred_valid_i),
        .cm_actual_i(cm_actual_i), .cm_valid_i(cm_valid_i), .flush_i(flush_i),
        .fb_pc_o(fb_pc_o), .fb_actual_o(fb_actual_o),
        .fb_mispredict_o(fb_mispredict_o), .fb_conf_o(fb_conf_o),
        .fb_valid_o(fb_valid_o), .count_o(count_o),
        .empty_o(empty_o), .full_o(full_o),
        .overflow_o(overflow_o), .underflow_o(underflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] res;
        logic        conf;
    } ent_t;

    typedef struct {
        logic [1:0]  v;
        logic [63:0] pc;
        logic [63:0] act;
        logic [1:0]  mis;
        logic [1:0]  conf;
        logic [4:0]  cnt;
        logic        ovf;
        logic        udf;
    } exp_t;

    ent_t m_q[$];
    exp_t exp_q[$];
    logic m_ovf = 1'b0;
    logic m_udf = 1'b0;
    int   n_err = 0;
    int   n_chk = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        pred_pc_i = '0; pred_result_i = '0; pred_conf_i = '0; pred_valid_i = '0;
        cm_actual_i = '0; cm_valid_i = '0; flush_i = 1'b0;
    endtask

    task automatic set_pred(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] r0,
                            input logic c0, input logic [31:0] pc1, input logic [31:0] r1, input logic c1);
        pred_valid_i = v;
        pred_pc_i = {pc1, pc0};
        pred_result_i = {r1, r0};
        pred_conf_i = {c1, c0};
    endtask

    task automatic set_cm(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] a1);
        cm_valid_i = v;
        cm_actual_i = {a1, a0};
    endtask

    // Reference queue model: computes what the DUT must show after the coming edge,
    // pushes it to the scoreboard, clocks, then pops and compares.
    task automatic do_cycle(input string tag);
        exp_t e;
        ent_t en;
        exp_t got;
        int   ncm, npr, k;
        e.v = '0; e.pc = '0; e.act = '0; e.mis = '0; e.conf = '0;
        ncm = int'(cm_valid_i[0]) + int'(cm_valid_i[1]);
        npr = int'(pred_valid_i[0]) + int'(pred_valid_i[1]);
        if (flush_i) begin
            m_q.delete();
        end else begin
            if (ncm > m_q.size()) begin
                m_udf = 1'b1;
            end else begin
                k = 0;
                for (int j = 0; j < 2; j++) begin
                    if (cm_valid_i[j]) begin
                        en = m_q[k];
                        e.v[j] = 1'b1;
                        e.pc[j*32 +: 32] = en.pc;
                        e.act[j*32 +: 32] = cm_actual_i[j*32 +: 32];
                        e.mis[j] = en.res != cm_actual_i[j*32 +: 32];
                        e.conf[j] = en.conf;
                        k++;
                    end
                end
                for (int j = 0; j < ncm; j++) m_q.delete(0);
            end
            if (m_q.size() + npr > 16) begin
                m_ovf = 1'b1;
            end else begin
                for (int j = 0; j < 2; j++) begin
                    if (pred_valid_i[j]) begin
                        en.pc = pred_pc_i[j*32 +: 32];
                        en.res = pred_result_i[j*32 +: 32];
                        en.conf = pred_conf_i[j];
                        m_q.push_back(en);
                    end
                end
            end
        end
        e.cnt = 5'(m_q.size());
        e.ovf = m_ovf;
        e.udf = m_udf;
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
        got = exp_q.pop_front();
        check({tag, ".fb_valid"}, 64'(fb_valid_o), 64'(got.v));
        check({tag, ".fb_pc"}, fb_pc_o, got.pc);
        check({tag, ".fb_actual"}, fb_actual_o, got.act);
        check({tag, ".fb_mis"}, 64'(fb_mispredict_o), 64'(got.mis));
        check({tag, ".fb_conf"}, 64'(fb_conf_o), 64'(got.conf));
        check({tag, ".count"}, 64'(count_o), 64'(got.cnt));
        check({tag, ".empty"}, 64'(empty_o), 64'(got.cnt == 5'd0));
        check({tag, ".full"}, 64'(full_o), 64'(got.cnt == 5'd16));
        check({tag, ".ovf"}, 64'(overflow_o), 64'(got.ovf));
        check({tag, ".udf"}, 64'(underflow_o), 64'(got.udf));
        idle();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".fb_valid"}, 64'(fb_valid_o), 64'd0);
        check({tag, ".fb_pc"}, fb_pc_o, 64'd0);
        check({tag, ".fb_actual"}, fb_actual_o, 64'd0);
        check({tag, ".fb_mis"}, 64'(fb_mispredict_o), 64'd0);
        check({tag, ".fb_conf"}, 64'(fb_conf_o), 64'd0);
        check({tag, ".count"}, 64'(count_o), 64'd0);
        check({tag, ".empty"}, 64'(empty_o), 64'd1);
        check({tag, ".full"}, 64'(full_o), 64'd0);
        check({tag, ".ovf"}, 64'(overflow_o), 64'd0);
        check({tag, ".udf"}, 64'(underflow_o), 64'd0);
    endtask

    initial begin
        idle();
        repeat (2) @(posedge clk_i);
        #1;
        check_reset_values("reset");
        rst_i = 1'b0;

        // Basic hit
        set_pred(2'b01, 32'h100, 32'h5, 1'b1, 32'h0, 32'h0, 1'b0);
        do_cycle("hit_enq");
        set_cm(2'b01, 32'h5, 32'h0);
        do_cycle("hit_cm");
        check("hit.valid", 64'(fb_valid_o), 64'h1);
        check("hit.pc0", 64'(fb_pc_o[31:0]), 64'h100);
        check("hit.act0", 64'(fb_actual_o[31:0]), 64'h5);
        check("hit.mis0", 64'(fb_mispredict_o[0]), 64'h0);
        check("hit.conf0", 64'(fb_conf_o[0]), 64'h1);
        check("hit.count", 64'(count_o), 64'h0);

        // Mispredict with commit compaction
        set_pred(2'b11, 32'h200, 32'hA, 1'b0, 32'h204, 32'hB, 1'b1);
        do_cycle("mp_enq");
        set_cm(2'b10, 32'h0, 32'hA);
        do_cycle("mp_cm1");
        check("mp1.valid", 64'(fb_valid_o), 64'h2);
        check("mp1.pc1", 64'(fb_pc_o[63:32]), 64'h200);
        check("mp1.mis1", 64'(fb_mispredict_o[1]), 64'h0);
        set_cm(2'b01, 32'hC, 32'h0);
        do_cycle("mp_cm2");
        check("mp2.valid", 64'(fb_valid_o), 64'h1);
        check("mp2.pc0", 64'(fb_pc_o[31:0]), 64'h204);
        check("mp2.mis0", 64'(fb_mispredict_o[0]), 64'h1);
        check("mp2.conf0", 64'(fb_conf_o[0]), 64'h1);

        // Fill, overflow, enqueue+commit at full, drain
        for (int i = 0; i < 8; i++) begin
            set_pred(2'b11, 32'h1000 + 32'(i*8), 32'(i), 1'b0, 32'h1004 + 32'(i*8), 32'(i+100), 1'b1);
            do_cycle("fill");
        end
        check("fill.full", 64'(full_o), 64'h1);
        check("fill.count", 64'(count_o), 64'd16);
        set_pred(2'b11, 32'hDEAD, 32'h1, 1'b1, 32'hBEEF, 32'h2, 1'b1);
        do_cycle("ovf");
        check("ovf.flag", 64'(overflow_o), 64'h1);
        check("ovf.count", 64'(count_o), 64'd16);
        set_pred(2'b11, 32'h1100, 32'h7, 1'b0, 32'h1104, 32'h8, 1'b0);
        set_cm(2'b11, 32'h0, 32'h64);
        do_cycle("full_swap");
        check("swap.count", 64'(count_o), 64'd16);
        check("swap.pc0", 64'(fb_pc_o[31:0]), 64'h1000);
        check("swap.pc1", 64'(fb_pc_o[63:32]), 64'h1004);
        for (int i = 0; i < 8; i++) begin
            set_cm(2'b11, 32'(i), 32'(i+100));
            do_cycle("drain");
        end
        check("drain.empty", 64'(empty_o), 64'h1);

        // Underflow
        set_pred(2'b01, 32'h300, 32'h3, 1'b0, 32'h0, 32'h0, 1'b0);
        do_cycle("udf_enq");
        set_cm(2'b11, 32'h3, 32'h3);
        do_cycle("udf_cm");
        check("udf.valid", 64'(fb_valid_o), 64'h0);
        check("udf.count", 64'(count_o), 64'h1);
        check("udf.flag", 64'(underflow_o), 64'h1);
        set_cm(2'b01, 32'h3, 32'h0);
        do_cycle("udf_drain");

        // Wrap-around under sustained two-wide traffic
        set_pred(2'b11, 32'h3000, 32'h0, 1'b0, 32'h3004, 32'h1, 1'b1);
        do_cycle("wrap_pre");
        for (int i = 1; i <= 20; i++) begin
            set_pred(2'b11, 32'h3000 + 32'(i*8), 32'(2*i), i[0], 32'h3004 + 32'(i*8), 32'(2*i+1), ~i[0]);
            set_cm(2'b11, 32'(2*(i-1)) + 32'(i % 3 == 0), 32'(2*(i-1)+1));
            do_cycle("wrap");
        end
        set_cm(2'b11, 32'd40, 32'd0);
        do_cycle("wrap_post");

        // Flush alongside a commit
        for (int i = 0; i < 3; i++) begin
            set_pred(2'b11, 32'h400 + 32'(i*8), 32'(i), 1'b0, 32'h404 + 32'(i*8), 32'(i), 1'b0);
            do_cycle("fl_fill");
        end
        check("fl.count6", 64'(count_o), 64'd6);
        flush_i = 1'b1;
        set_cm(2'b11, 32'h0, 32'h0);
        do_cycle("flush");
        check("fl.count", 64'(count_o), 64'd0);
        check("fl.empty", 64'(empty_o), 64'h1);
        check("fl.valid", 64'(fb_valid_o), 64'h0);

        // Asynchronous reset between edges, with live state and feedback
        set_pred(2'b11, 32'h500, 32'h1, 1'b1, 32'h504, 32'h2, 1'b1);
        do_cycle("ar_enq");
        set_cm(2'b01, 32'h9, 32'h0);
        do_cycle("ar_cm");
        #3;
        rst_i = 1'b1;
        #1;
        check_reset_values("async_reset");
        m_q.delete();
        exp_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        set_pred(2'b10, 32'h0, 32'h0, 1'b0, 32'h600, 32'h6, 1'b1);
        do_cycle("post_enq");
        set_cm(2'b01, 32'h6, 32'h0);
        do_cycle("post_cm");
        check("post.pc0", 64'(fb_pc_o[31:0]), 64'h600);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
